// File: rtl/btn_events.sv
// Classifies debounced button presses into SHORT/LONG events and queues them
// in a small FIFO that is drained through a valid/ack handshake.
module btn_events #(
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       btn,
  input  logic                       flush,
  output logic                       event_valid,
  output logic [1:0]                 event_code,
  input  logic                       event_ack,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] CODE_SHORT = 2'b01;
  localparam logic [1:0] CODE_LONG  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_WAIT_REL
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          push_c;
  logic [1:0]    push_code_c;

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop_c;
  logic          push_ok_c;

  // Classifier state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Classifier next-state; a flush abandons any press and waits for release
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    push_c       = 1'b0;
    push_code_c  = CODE_SHORT;
    if (flush) begin
      state_nxt    = btn ? S_WAIT_REL : S_IDLE;
      hold_cnt_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (btn) begin
            state_nxt    = S_PRESSED;
            hold_cnt_nxt = '0;
          end
        end
        S_PRESSED: begin
          if (!btn) begin
            push_c      = 1'b1;
            push_code_c = CODE_SHORT;
            state_nxt   = S_IDLE;
          end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            push_c      = 1'b1;
            push_code_c = CODE_LONG;
            state_nxt   = S_WAIT_REL;
          end else begin
            hold_cnt_nxt = hold_cnt + HW'(1);
          end
        end
        S_WAIT_REL: begin
          if (!btn) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign pop_c     = event_ack && (count != '0) && !flush;
  assign push_ok_c = push_c && ((count != CW'(DEPTH)) || pop_c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok_c) - CW'(pop_c);
      if (push_c && !push_ok_c) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy gates what is visible
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_code_c;
  end

  assign event_valid = (count != '0);
  assign event_code  = event_valid ? mem[rd_ptr] : 2'b00;

endmodule

// File: tb/tb_btn_events.sv
// Randomized and directed checks of btn_events against a queue-based model.
module tb_btn_events;

  localparam int H = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn;
  logic       flush;
  logic       event_ack;
  logic       event_valid;
  logic [1:0] event_code;
  logic [2:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  btn_events #(.HOLD_CYCLES(H), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .btn(btn), .flush(flush),
    .event_valid(event_valid), .event_code(event_code),
    .event_ack(event_ack), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Model: press = run of consecutive 1 samples; armed means the run can still classify
  logic [1:0] mq[$];
  bit         m_ovf;
  int         m_run;
  bit         m_armed;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_run   = 0;
      m_armed = 1'b1;
    end else if (flush) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_run   = 0;
      m_armed = !btn;
    end else begin
      bit ev;
      logic [1:0] code;
      ev = 1'b0;
      code = 2'b00;
      if (btn) begin
        m_run++;
        if (m_armed && m_run == H + 1) begin
          ev = 1'b1; code = 2'b10; m_armed = 1'b0;
        end
      end else begin
        if (m_armed && m_run >= 1) begin
          ev = 1'b1; code = 2'b01;
        end
        m_run = 0;
        m_armed = 1'b1;
      end
      if (event_ack && mq.size() > 0) void'(mq.pop_front());
      if (ev) begin
        if (mq.size() < D) mq.push_back(code);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("valid", int'(event_valid), int'(mq.size() > 0));
      chk("code", int'(event_code), (mq.size() > 0) ? int'(mq[0]) : 0);
      chk("count", int'(count), mq.size());
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic short_press();
    btn = 1'b1; tick(2);
    btn = 1'b0; tick(2);
  endtask

  task automatic long_press();
    btn = 1'b1; tick(H + 1);
    btn = 1'b0; tick(2);
  endtask

  task automatic drain_expect(input logic [1:0] code, input string name);
    chk(name, int'(event_code), int'(code));
    event_ack = 1'b1; tick(1); event_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; btn = 1'b0; flush = 1'b0; event_ack = 1'b0;
    tick(3);
    chk("reset_count", int'(count), 0);
    chk("reset_valid", int'(event_valid), 0);
    chk("reset_code", int'(event_code), 0);
    reset_n = 1'b1; tick(2);

    // SHORT at the longest short length: btn high for exactly H edges
    btn = 1'b1; tick(H);
    chk("short_not_yet", int'(count), 0);
    btn = 1'b0; tick(1);
    chk("short_count", int'(count), 1);
    chk("short_code", int'(event_code), 1);
    chk("model_size_short", mq.size(), 1);
    event_ack = 1'b1; tick(1); event_ack = 1'b0;
    chk("short_pop_count", int'(count), 0);
    chk("short_pop_valid", int'(event_valid), 0);
    tick(2);

    // LONG fires at E0+H while still held; release adds nothing
    btn = 1'b1; tick(H);
    chk("long_not_yet", int'(count), 0);
    tick(1);
    chk("long_count", int'(count), 1);
    chk("long_code", int'(event_code), 2);
    tick(11);
    btn = 1'b0; tick(3);
    chk("long_single", int'(count), 1);
    drain_expect(2'b10, "long_drain");
    tick(2);

    // Overflow on the fifth press, sticky through a full drain
    repeat (5) short_press();
    chk("ovf_count", int'(count), 4);
    chk("ovf_flag", int'(overflow), 1);
    repeat (4) drain_expect(2'b01, "ovf_drain");
    chk("ovf_empty", int'(count), 0);
    chk("ovf_sticky", int'(overflow), 1);
    flush = 1'b1; tick(1); flush = 1'b0;
    chk("flush_clears_ovf", int'(overflow), 0);
    tick(2);

    // Full FIFO: pop and SHORT classify on the same edge
    repeat (4) long_press();
    chk("full_count", int'(count), 4);
    btn = 1'b1; tick(2);
    btn = 1'b0; event_ack = 1'b1; tick(1); event_ack = 1'b0;
    chk("simul_count", int'(count), 4);
    chk("simul_ovf", int'(overflow), 0);
    repeat (3) drain_expect(2'b10, "simul_drain_long");
    drain_expect(2'b01, "simul_last_short");
    tick(2);

    // Flush mid-press discards the press and the rest of that hold
    repeat (3) short_press();
    chk("pre_flush_count", int'(count), 3);
    btn = 1'b1; tick(3);
    flush = 1'b1; tick(1); flush = 1'b0;
    chk("flush_count", int'(count), 0);
    chk("flush_ovf", int'(overflow), 0);
    tick(12);
    btn = 1'b0; tick(3);
    chk("flush_no_event", int'(count), 0);
    btn = 1'b1; tick(3);
    btn = 1'b0; tick(1);
    chk("post_flush_count", int'(count), 1);
    chk("post_flush_code", int'(event_code), 1);
    drain_expect(2'b01, "post_flush_drain");

    // Asynchronous reset mid-press with two entries queued
    short_press(); short_press();
    chk("prereset_count", int'(count), 2);
    btn = 1'b1; tick(3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_valid", int'(event_valid), 0);
    chk("async_code", int'(event_code), 0);
    chk("async_ovf", int'(overflow), 0);
    tick(2);
    btn = 1'b0; reset_n = 1'b1;
    tick(10);
    chk("post_reset_quiet", int'(count), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5, 0) == 0) btn = ~btn;
      event_ack = ($urandom_range(4, 0) == 0);
      flush = ($urandom_range(99, 0) == 0);
      tick(1);
    end
    btn = 1'b0; event_ack = 1'b0; flush = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btn_events.md
# btn_events

Press classifier and event queue that sits directly downstream of the button debouncer. It turns the debounced `btn` level into discrete SHORT/LONG press events and queues them in a small FIFO. The CPU's input logic drains the queue through a valid/ack handshake. The debouncer's one-cycle `reset` pulse acts as a synchronous flush of this block.

## Interface

- `HOLD_CYCLES`, default 64: press length in clk cycles that qualifies as LONG. Must be ≥ 2.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, ≥ 2.

- `clk` in 1: single clock; every register is clocked on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn` in 1: debounced button level from the debouncer.
- `flush` in 1: synchronous clear, driven by the debouncer's `reset` pulse.
- `event_valid` out 1: FIFO not empty.
- `event_code` out 2: head entry. 2'b01 = SHORT, 2'b10 = LONG; 2'b00 whenever empty.
- `event_ack` in 1: pop the head. Effective only while `event_valid` is high.
- `count` out clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when an event is dropped because the FIFO is full.

## Operation

- **FSM states:** IDLE, PRESSED, WAIT_REL.
  - IDLE, `btn`=1: go to PRESSED; `hold_cnt` cleared to 0.
  - PRESSED, `btn`=1, `hold_cnt` < HOLD_CYCLES-1: `hold_cnt`++.
  - PRESSED, `btn`=1, `hold_cnt` == HOLD_CYCLES-1: push LONG; go to WAIT_REL.
  - PRESSED, `btn`=0: push SHORT; go to IDLE.
  - WAIT_REL, `btn`=0: go to IDLE; no event.
- **`hold_cnt` width:** clog2(HOLD_CYCLES). It never wraps.
- **FIFO:**
  - Circular buffer with rd/wr pointers of clog2(DEPTH) bits; wrap modulo DEPTH.
  - `count` is tracked separately.
  - Head is presented combinationally from storage.
- **Push when full, no pop same cycle:** event dropped, `overflow`←1, storage and pointers unchanged.
- **Push and pop in the same cycle:** both happen; `count` unchanged.
  - Applies when full: pop frees the slot, push accepted, no overflow.
  - Applies when count==1: new event becomes head next cycle.
- **`event_ack` while empty:** ignored; no pointer or count change.
- **`flush`=1 (takes priority over push/pop that cycle):**
  - `count`←0, pointers←0, `overflow`←0.
  - FSM←WAIT_REL if `btn`=1, else IDLE. A press in progress is discarded and yields no event.
- **`reset_n`=0 (asynchronous, any time):** FSM=IDLE, `hold_cnt`=0, pointers=0, `count`=0, `overflow`=0. FIFO storage contents are don't-care.
- **Reset values of outputs:** `event_valid`=0, `event_code`=2'b00, `count`=0, `overflow`=0.

## Timing

- Rising edge E0 is the first edge at which `btn`=1 is sampled in IDLE.
- **SHORT press:** `btn` first sampled 0 at edge E0+N, with 1 ≤ N ≤ HOLD_CYCLES. SHORT is pushed at E0+N.
- **LONG press:** `btn` sampled 1 at edges E0..E0+HOLD_CYCLES. LONG is pushed at E0+HOLD_CYCLES, while the button is still held.
- **Push-to-visible latency:**
  - `event_valid`, `event_code` and `count` reflect a push immediately after the push edge.
  - Empty-to-nonempty is a one-edge latency from the classifying sample.
- **Pop:** takes effect at the edge where `event_valid` & `event_ack` = 1. Next head is visible after that edge.
- **Ack hold:** holding `event_ack` high pops one entry per cycle.
- **`overflow`:** sets on the dropping edge. Clears only on `flush` or `reset_n`.
- **No combinational paths** from `btn`/`flush` to outputs. `event_ack` affects outputs only through registers.

## Test plan

- **Reset:** assert `reset_n`=0 mid-press with count=2 → outputs read 0 asynchronously. Deassert with `btn`=0 → no event for 10 cycles.
- **SHORT, HOLD_CYCLES=8:** `btn` high for 8 edges → SHORT pushed; `event_code`=01, `count`=1. Ack → `count`=0, `event_valid`=0.
- **LONG, HOLD_CYCLES=8:** `btn` high for 20 edges → LONG pushed at E0+8; exactly one event in total; `event_code`=10.
- **Overflow, DEPTH=4:** 5 SHORT presses, no ack → `count`=4, `overflow`=1. Drain 4 acks → codes 01×4, `overflow` still 1.
- **Full FIFO, simultaneous events:** with count=4, ack asserted on the same edge a SHORT is classified → `count` stays 4, `overflow`=0, new entry is the last popped.
- **Flush mid-press:** flush while in PRESSED with count=3 → `count`=0, `overflow`=0. Continued hold and release produce no event; the next press produces a normal event.
